block_output: RTL and testbench
===============================

Name: block_output

Overview:
- Router output port, the transmit-side counterpart of the router input block.
- Arbitrates among the NPORT router input blocks (N, E, S, W, Local) requesting this direction and accepts one 8-bit flit per grant into a small FIFO.
- Drives the flits to the neighbouring router's input over the val/ret link handshake.
- One instance per router output direction.

Parameters:
- DATA_W, 8, flit width in bits.
- NPORT, 5, number of requesting input blocks; index order N=0, E=1, S=2, W=3, L=4.
- FIFO_DEPTH, 4, output buffer depth in flits; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NPORT  request vector; req[i] is high while input block i holds a flit for this direction.
- data_in  input  NPORT*DATA_W  flit buses; slice i is data_in[i*DATA_W +: DATA_W].
- grant  output  NPORT  registered one-hot grant; all zeros means no grant.
- val  output  1  flit valid towards the neighbour.
- ret  input  1  neighbour accept; a flit transfers on a rising edge where val && ret.
- Data_out  output  DATA_W  flit towards the neighbour; equals the FIFO head while val=1.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): grant=0, val=0, Data_out=0, FIFO empty, round-robin pointer=0, gap flag=0. Any in-flight flit is dropped.
- Arbitration (edge at end of cycle t):
  - grant[i] is set for cycle t+1 when all of the following hold: req[i]=1 in t, port i wins round-robin, grant=0 in t, and count_t + (grant in t ? 1 : 0) < FIFO_DEPTH.
  - Otherwise grant=0.
- Gap rule: a grant lasts exactly one cycle and is always followed by at least one cycle of grant=0. Maximum intake is 1 flit per 2 cycles. This gives the requester a cycle to drop or advance req.
- Round-robin:
  - Search starts at the pointer and wraps modulo NPORT.
  - After granting port i, the pointer becomes (i+1) mod NPORT.
  - With no grant, the pointer holds.
- Capture: in a grant cycle, data_in slice i is written to the FIFO at the closing edge. The requester must hold that slice stable throughout the grant cycle.
- Link side:
  - val = FIFO not empty (registered state, no combinational path from ret).
  - Data_out = head flit; it changes only after a pop or when the first flit arrives in an empty FIFO.
  - Pop on an edge where val && ret.
  - ret while val=0 is ignored.
- Latency: req high in cycle t with empty FIFO -> grant in t+1 -> val=1 and Data_out valid in t+2.
- Simultaneous push and pop: both occur and count is unchanged. This is legal when the FIFO is full and ret=1, but no new grant is issued that cycle, because the full check uses the pre-pop count.
- Full: grants stall, req is held by the requesters, and no flit is lost or overwritten.
- Empty: val=0 and Data_out holds its last value (0 after reset).
- Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH, width clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: BLOCK_OUTPUT_LOCAL_PRIORITY_EN.
- Defined: when req[NPORT-1] (Local) is high and a grant is otherwise allowed, Local always wins. The round-robin pointer does not update on a Local grant. The other ports rotate normally when Local is idle.
- Undefined: pure round-robin over all NPORT ports.

Decomposition:
- Shared package noc_pkg:
  - DATA_W and NPORT defaults.
  - Port index constants PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_L=4, which are the same encoding the input block's register output uses.
  - Function clog2.
- Sub-module noc_rr_arbiter: takes req, pointer and enable; returns a one-hot winner and the next pointer. The FIFO stays inline.

Test Plan:
- Reset then idle: rst pulse, req=0 for 10 cycles -> grant=0, val=0, Data_out=8'h00 throughout.
- Single flit: req=5'b00001, slice0=8'hAE, ret=1 -> grant=5'b00001 one cycle later; val=1 with Data_out=8'hAE the next cycle; popped on the following edge; val=0 after.
- Round-robin fairness: req=5'b10101 held, slices 8'h11/8'h33/8'h55, ret=1 -> grant order 00001, 00100, 10000, 00001, with an idle grant cycle between each; Data_out sequence 11, 33, 55, 11.
- Back-pressure/full: ret=0, req=5'b00010, slice1 incrementing from 8'hF0 -> exactly 4 grants, then grant stays 0 and val stays 1 with Data_out=8'hF0. Raising ret drains F0..F3 in order and grants resume.
- Reset mid-operation: FIFO holding 3 flits, rst asserted between edges -> val, grant and Data_out go to 0 immediately (asynchronously); after release the first grant goes to port 0 when req=5'b11111.
- With BLOCK_OUTPUT_LOCAL_PRIORITY_EN: req=5'b10011 held, ret=1 -> grant=5'b10000 every grant slot. When req[4] drops, grants alternate 00001, 00010.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default widths, port index encoding and a
// constant-width helper used by the input and output blocks.
package noc_pkg;

   localparam int DATA_W = 8;
   localparam int NPORT  = 5;

   localparam int PORT_N = 0;
   localparam int PORT_E = 1;
   localparam int PORT_S = 2;
   localparam int PORT_W = 3;
   localparam int PORT_L = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner and next search pointer.
// Build option BLOCK_OUTPUT_LOCAL_PRIORITY_EN gives the Local port absolute priority.
module noc_rr_arbiter #(
   parameter int NPORT = noc_pkg::NPORT,
   parameter int PTR_W = noc_pkg::clog2(noc_pkg::NPORT)
) (
   input  logic [NPORT-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             enable,
   output logic [NPORT-1:0] winner,
   output logic [PTR_W-1:0] next_ptr
);

   logic             found;
   logic [PTR_W-1:0] idx;
   int               cand;

   always_comb begin
      winner   = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = '0;
      cand     = 0;
      if (enable) begin
`ifdef BLOCK_OUTPUT_LOCAL_PRIORITY_EN
         // Local wins outright and leaves the rotation untouched
         if (req[NPORT-1]) begin
            winner[NPORT-1] = 1'b1;
            found           = 1'b1;
         end
`endif
         for (int k = 0; k < NPORT; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NPORT) begin
               cand = cand - NPORT;
            end
            idx = PTR_W'(cand);
            if (!found && req[idx]) begin
               winner[idx] = 1'b1;
               found       = 1'b1;
               next_ptr    = (idx == PTR_W'(NPORT - 1)) ? '0 : idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/block_output.sv
// Router output port: arbitrates input blocks into a small FIFO and drives the
// val/ret link. Build option: BLOCK_OUTPUT_LOCAL_PRIORITY_EN (Local always wins).
module block_output #(
   parameter int DATA_W     = noc_pkg::DATA_W,
   parameter int NPORT      = noc_pkg::NPORT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORT-1:0]        req,
   input  logic [NPORT*DATA_W-1:0] data_in,
   output logic [NPORT-1:0]        grant,
   output logic                    val,
   input  logic                    ret,
   output logic [DATA_W-1:0]       Data_out
);

   import noc_pkg::*;

   localparam int PTR_W = clog2(NPORT);
   localparam int AW    = clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;

   logic [NPORT-1:0]  winner;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  next_ptr;
   logic              enable;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] next_head;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_next;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  committed;

   assign push      = |grant;
   assign pop       = val && ret;
   assign val       = (count != '0);
   assign rd_next   = rd_ptr + 1'b1;
   assign committed = count + CNT_W'(push);
   // A grant is never back-to-back, and room is judged on the pre-pop count
   assign enable    = !push && (committed < CNT_W'(FIFO_DEPTH));

   noc_rr_arbiter #(
      .NPORT (NPORT),
      .PTR_W (PTR_W)
   ) u_arb (
      .req      (req),
      .ptr      (rr_ptr),
      .enable   (enable),
      .winner   (winner),
      .next_ptr (next_ptr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         grant  <= winner;
         rr_ptr <= next_ptr;
      end
   end

   always_comb begin
      push_data = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (grant[i]) begin
            push_data = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_next;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head register holds its value while empty, so it only follows real arrivals
   always_comb begin
      next_head = Data_out;
      if (pop && (count > CNT_W'(1))) begin
         next_head = mem[rd_next];
      end else if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
         next_head = push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Data_out <= '0;
      end else begin
         Data_out <= next_head;
      end
   end

endmodule

// File: tb/tb_block_output.sv
// Self-checking bench for block_output: directed phases plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_block_output;

   localparam int DW    = 8;
   localparam int NP    = 5;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    req;
   logic [NP*DW-1:0] data_in;
   logic [NP-1:0]    grant;
   logic             val;
   logic             ret;
   logic [DW-1:0]    Data_out;

   int passed = 0;
   int total  = 0;

   int mq[$];
   int m_rr;
   int m_gnt;
   int m_head;

   always #5 clk = ~clk;

   block_output #(
      .DATA_W     (DW),
      .NPORT      (NP),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data_in  (data_in),
      .grant    (grant),
      .val      (val),
      .ret      (ret),
      .Data_out (Data_out)
   );

   function automatic logic [NP*DW-1:0] packData(input logic [7:0] d0, input logic [7:0] d1,
                                                 input logic [7:0] d2, input logic [7:0] d3,
                                                 input logic [7:0] d4);
      return {d4, d3, d2, d1, d0};
   endfunction

   task automatic modelReset();
      mq.delete();
      m_rr   = 0;
      m_gnt  = -1;
      m_head = 0;
   endtask

   // Reference: one cycle of the output port in terms of a flit queue
   task automatic modelStep();
      int nxt;
      int cap;
      int p;
      bit do_pop;
      nxt    = -1;
      cap    = -1;
      do_pop = (mq.size() > 0) && (ret === 1'b1);
      if (m_gnt >= 0) begin
         cap = int'(data_in[m_gnt*DW +: DW]);
      end
      if (m_gnt < 0 && mq.size() < DEPTH) begin
`ifdef BLOCK_OUTPUT_LOCAL_PRIORITY_EN
         if (req[NP-1]) begin
            nxt = NP - 1;
         end
`endif
         for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (nxt < 0 && req[p]) begin
               nxt  = p;
               m_rr = (p + 1) % NP;
            end
         end
      end
      if (do_pop) begin
         void'(mq.pop_front());
      end
      if (cap >= 0) begin
         mq.push_back(cap);
      end
      if (mq.size() > 0) begin
         m_head = mq[0];
      end
      m_gnt = nxt;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic checkModel(input string tag);
      logic [31:0] eg;
      eg = (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0;
      checkOutput({tag, ".grant"}, 32'(grant), eg);
      checkOutput({tag, ".val"}, 32'(val), (mq.size() > 0) ? 32'd1 : 32'd0);
      checkOutput({tag, ".data"}, 32'(Data_out), 32'(m_head));
   endtask

   task automatic applyStimulus(input logic [NP-1:0] r, input logic [NP*DW-1:0] d,
                                input logic rt, input string tag);
      req     = r;
      data_in = d;
      ret     = rt;
      modelStep();
      @(posedge clk);
      #1;
      checkModel(tag);
   endtask

   initial begin
      logic [7:0]       d1;
      bit               was;
      logic [NP*DW-1:0] d;

      rst     = 1'b1;
      req     = '0;
      data_in = '0;
      ret     = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.grant", 32'(grant), 32'd0);
      checkOutput("reset.val", 32'(val), 32'd0);
      checkOutput("reset.data", 32'(Data_out), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         applyStimulus('0, '0, 1'b0, "idle");
      end

      d = packData(8'hAE, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(5'b00001, d, 1'b1, "single1");
      checkOutput("single.grant", 32'(grant), 32'h01);
      applyStimulus(5'b00000, d, 1'b1, "single2");
      checkOutput("single.val", 32'(val), 32'd1);
      checkOutput("single.head", 32'(Data_out), 32'hAE);
      applyStimulus(5'b00000, d, 1'b1, "single3");
      checkOutput("single.drained", 32'(val), 32'd0);

      d = packData(8'h11, 8'h00, 8'h33, 8'h00, 8'h55);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'b10101, d, 1'b1, "rr");
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus('0, d, 1'b1, "rr_drain");
      end

      d1 = 8'hF0;
      for (int i = 0; i < 14; i++) begin
         was = (m_gnt == 1);
         applyStimulus(5'b00010, packData(8'h00, d1, 8'h00, 8'h00, 8'h00), 1'b0, "full");
         if (was) d1 = d1 + 8'h01;
      end
      checkOutput("full.val", 32'(val), 32'd1);
      checkOutput("full.head", 32'(Data_out), 32'hF0);
      checkOutput("full.nogrant", 32'(grant), 32'd0);
      for (int i = 0; i < 14; i++) begin
         was = (m_gnt == 1);
         applyStimulus(5'b00010, packData(8'h00, d1, 8'h00, 8'h00, 8'h00), 1'b1, "full_drain");
         if (was) d1 = d1 + 8'h01;
      end

      for (int i = 0; i < 400; i++) begin
         applyStimulus(NP'($urandom_range(0, 31)), (NP*DW)'({$urandom(), $urandom()}),
                       ($urandom_range(0, 3) != 0), "random");
      end

      for (int i = 0; i < 10; i++) begin
         applyStimulus('0, '0, 1'b1, "pre_reset_drain");
      end
      d = packData(8'h00, 8'h00, 8'h5A, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(5'b00100, d, 1'b0, "fill3");
      end
      checkOutput("fill3.val", 32'(val), 32'd1);
      rst = 1'b1;
      #2;
      checkOutput("async_reset.grant", 32'(grant), 32'd0);
      checkOutput("async_reset.val", 32'(val), 32'd0);
      checkOutput("async_reset.data", 32'(Data_out), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      d = packData(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
      applyStimulus(5'b11111, d, 1'b1, "post_reset");
`ifdef BLOCK_OUTPUT_LOCAL_PRIORITY_EN
      checkOutput("post_reset.first", 32'(grant), 32'h10);
`else
      checkOutput("post_reset.first", 32'(grant), 32'h01);
`endif
      for (int i = 0; i < 6; i++) begin
         applyStimulus(5'b11111, d, 1'b1, "post_reset_run");
      end

      d = packData(8'hC0, 8'hC1, 8'h00, 8'h00, 8'hC4);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'b10011, d, 1'b1, "local_held");
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'b00011, d, 1'b1, "local_idle");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
